// File: rtl/pipe_stage_skid_if.sv
// Valid/ready payload channel between pipeline stages.
// The master drives valid and data. The slave drives ready.
interface pipe_stage_skid_if #(
    parameter int DATA_W = 106
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with an optional 2-entry skid buffer, synchronous flush,
// occupancy reporting and a saturating stall counter.
module pipe_stage_skid #(
    parameter int DATA_W  = 106,
    parameter int SKID_EN = 1,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic               cnt_clr_i,
    pipe_stage_skid_if.slave   in_i,
    pipe_stage_skid_if.master  out_o,
    output logic [1:0]         occ_o,
    output logic [CNT_W-1:0]   stall_cnt_o
);

    // The encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  main_q, main_d;
    logic [DATA_W-1:0]  skid_q, skid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               in_ready;
    logic               out_valid;
    logic               accept;
    logic               emit;

    assign out_valid = (state_q != EMPTY);

    // With the skid buffer, in_ready depends only on registered state.
    // That keeps out_ready off any combinational path.
    assign in_ready  = (SKID_EN != 0) ? (state_q != TWO) : (!out_valid || out_o.ready);
    assign accept    = in_i.valid && in_ready;
    assign emit      = out_valid && out_o.ready;

    assign in_i.ready   = in_ready;
    assign out_o.valid  = out_valid;
    assign out_o.data   = main_q;
    assign occ_o        = state_q;
    assign stall_cnt_o  = cnt_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        main_d  = in_i.data;
                    end
                end
                ONE: begin
                    if (accept && emit) begin
                        main_d = in_i.data;
                    end else if (accept) begin
                        state_d = TWO;
                        skid_d  = in_i.data;
                    end else if (emit) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (emit) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // A clear beats a same-cycle increment. A flush does not affect the counter.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr_i) begin
            cnt_d = '0;
        end else if (out_valid && !out_o.ready && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
